// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared encodings for the memory-mapped UART transmitter.
// Holds the FSM state type, register offsets, STATUS bit positions and counter width.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned TXDATA_OFS    = 32'd0;
  localparam int unsigned STATUS_OFS    = 32'd4;

  localparam int unsigned STAT_BUSY_BIT = 32'd0;
  localparam int unsigned STAT_DONE_BIT = 32'd1;
  localparam int unsigned STAT_OVR_BIT  = 32'd2;

  localparam int unsigned CNT_W         = 32'd16;

endpackage

// File: rtl/uart_tx_mmio_baud_counter.sv
// baud_counter: loadable down-counter that measures one serial bit period.
// o_tick marks the last cycle of a period while counting is enabled.
module baud_counter
  import uart_tx_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_tick
);

  logic [W-1:0] r_count;

  // Load has priority; the count parks at zero once a period has expired.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != {W{1'b0}})) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tick = i_en && (r_count == {W{1'b0}});

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TXDATA and STATUS registers.
// A TXDATA store from IDLE starts a frame on the same edge; stores while busy flag overrun.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0030,
  parameter int unsigned           BAUD_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Address_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  input  logic                  MemWrite_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam logic [DATA_WIDTH-1:0] TX_ADDR     = BASE_ADDR + DATA_WIDTH'(TXDATA_OFS);
  localparam logic [DATA_WIDTH-1:0] ST_ADDR     = BASE_ADDR + DATA_WIDTH'(STATUS_OFS);
  localparam logic [CNT_W-1:0]      BAUD_RELOAD = CNT_W'(BAUD_DIV - 32'd1);

  tx_state_e  r_state;
  tx_state_e  w_state_nxt;
  logic [7:0] r_tx_byte;
  logic [7:0] w_byte_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_idx_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       r_overrun;
  logic       w_ovr_nxt;
  logic       r_tx;
  logic       w_tx_nxt;
  logic       r_busy;

  logic       w_sel_tx;
  logic       w_sel_st;
  logic       w_wr_tx;
  logic       w_wr_st;
  logic       w_tick;
  logic       w_load;
  logic       w_cnt_en;
  logic       w_done_set;
  logic       w_ovr_set;
  logic       w_unused_bits;

  // Only the word address is decoded; byte offset and upper store data are don't-care.
  assign w_sel_tx      = (Address_i[DATA_WIDTH-1:2] == TX_ADDR[DATA_WIDTH-1:2]);
  assign w_sel_st      = (Address_i[DATA_WIDTH-1:2] == ST_ADDR[DATA_WIDTH-1:2]);
  assign w_wr_tx       = MemWrite_i && w_sel_tx;
  assign w_wr_st       = MemWrite_i && w_sel_st;
  assign w_cnt_en      = (r_state != IDLE);
  assign w_unused_bits = ^{Address_i[1:0], WriteData_i[DATA_WIDTH-1:8]};

  baud_counter #(
    .W (CNT_W)
  ) u_baud (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_en       (w_cnt_en),
    .i_load_val (BAUD_RELOAD),
    .o_tick     (w_tick)
  );

  // Frame sequencing: next state, byte latch, bit index and counter reload.
  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_tx_byte;
    w_idx_nxt   = r_bit_idx;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr_tx) begin
          w_state_nxt = START;
          w_byte_nxt  = WriteData_i[7:0];
          w_idx_nxt   = 3'd0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) begin
          w_state_nxt = STOP;
          w_idx_nxt   = 3'd0;
          w_load      = 1'b1;
        end else if (w_tick) begin
          w_idx_nxt   = r_bit_idx + 3'd1;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Line level is computed from the next state so tx_o is a clean register output.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      IDLE:    w_tx_nxt = 1'b1;
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_byte_nxt[w_idx_nxt];
      STOP:    w_tx_nxt = 1'b1;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Sticky flags: a set on the same edge as a software clear takes precedence.
  always_comb begin
    w_done_set = (r_state == STOP) && w_tick;
    w_ovr_set  = w_wr_tx && (r_state != IDLE);
    if (w_done_set) begin
      w_done_nxt = 1'b1;
    end else if (w_wr_st && WriteData_i[STAT_DONE_BIT]) begin
      w_done_nxt = 1'b0;
    end else begin
      w_done_nxt = r_done;
    end
    if (w_ovr_set) begin
      w_ovr_nxt = 1'b1;
    end else if (w_wr_st && WriteData_i[STAT_OVR_BIT]) begin
      w_ovr_nxt = 1'b0;
    end else begin
      w_ovr_nxt = r_overrun;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tx_byte <= 8'h00;
      r_bit_idx <= 3'd0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_byte <= w_byte_nxt;
      r_bit_idx <= w_idx_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_ovr_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  // Combinational register read port.
  always_comb begin
    ReadData_o = {DATA_WIDTH{1'b0}};
    if (w_sel_tx) begin
      ReadData_o[7:0] = r_tx_byte;
    end else if (w_sel_st) begin
      ReadData_o[STAT_BUSY_BIT] = r_busy;
      ReadData_o[STAT_DONE_BIT] = r_done;
      ReadData_o[STAT_OVR_BIT]  = r_overrun;
    end else begin
      ReadData_o = {DATA_WIDTH{1'b0}};
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with BAUD_DIV=4: expected line bits are queued
// when a frame is requested and popped while the serial line is sampled.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1001_0030;
  localparam logic [31:0] TXA  = 32'h1001_0030;
  localparam logic [31:0] STA  = 32'h1001_0034;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address_i;
  logic [31:0] WriteData_i;
  logic        MemWrite_i;
  logic [31:0] ReadData_o;
  logic        tx_o;
  logic        busy_o;

  int   errors = 0;
  int   checks = 0;
  logic exp_bits[$];

  uart_tx_mmio #(
    .DATA_WIDTH (32),
    .BASE_ADDR  (BASE),
    .BAUD_DIV   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Address_i   (Address_i),
    .WriteData_i (WriteData_i),
    .MemWrite_i  (MemWrite_i),
    .ReadData_o  (ReadData_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] data);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
    exp_bits.push_back(1'b1);
  endtask

  // Called at a negedge; the store is sampled on the following posedge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address_i   = addr;
    WriteData_i = data;
    MemWrite_i  = 1'b1;
    @(negedge clk);
    MemWrite_i  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Address_i = addr;
    #1;
    chk(tag, ReadData_o, exp);
  endtask

  // Samples 40 frame cycles, optionally injecting one store at cycle inj.
  task automatic run_frame(input string tag, input int inj, input logic [31:0] inj_addr,
                           input logic [31:0] inj_data, input logic [31:0] mid_exp);
    logic cur;
    cur = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) begin
        if (exp_bits.size() != 0) cur = exp_bits.pop_front();
        else cur = 1'bx;
      end
      chk1($sformatf("%s tx k=%0d", tag, k), tx_o, cur);
      chk1($sformatf("%s busy k=%0d", tag, k), busy_o, 1'b1);
      if (k == inj) begin
        Address_i   = inj_addr;
        WriteData_i = inj_data;
        MemWrite_i  = 1'b1;
      end else begin
        MemWrite_i  = 1'b0;
        Address_i   = STA;
      end
      if (inj >= 0 && k == inj + 2) begin
        #1;
        chk({tag, " mid_status"}, ReadData_o, mid_exp);
      end
      @(negedge clk);
    end
    MemWrite_i = 1'b0;
    chk1({tag, " busy_end"}, busy_o, 1'b0);
    chk1({tag, " tx_end"}, tx_o, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    MemWrite_i  = 1'b0;
    Address_i   = TXA;
    WriteData_i = 32'h0;
    #1;
    chk1("rst tx", tx_o, 1'b1);
    chk1("rst busy", busy_o, 1'b0);
    @(negedge clk);
    read_chk("rst txdata", TXA, 32'h0);
    read_chk("rst status", STA, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First edge after reset release accepts the frame.
    push_frame(8'h55);
    bus_write(TXA, 32'h0000_0055);
    run_frame("f55", -1, STA, 32'h0, 32'h0);
    read_chk("f55 status", STA, 32'h2);
    read_chk("f55 txdata", TXA, 32'h55);
    @(negedge clk);

    // STATUS bit0 is not writable; then clear done.
    bus_write(STA, 32'h1);
    read_chk("st bit0 write", STA, 32'h2);
    @(negedge clk);
    bus_write(STA, 32'h2);
    read_chk("done clear", STA, 32'h0);
    @(negedge clk);

    // Store during a frame is dropped and flags overrun.
    push_frame(8'hA3);
    bus_write(TXA, 32'h0000_00A3);
    run_frame("fA3", 9, TXA, 32'h0000_007E, 32'h5);
    read_chk("fA3 status", STA, 32'h6);
    read_chk("fA3 txdata", TXA, 32'hA3);
    @(negedge clk);

    bus_write(STA, 32'h6);
    read_chk("clear both", STA, 32'h0);
    @(negedge clk);

    // Clear of done on the same edge that sets it loses.
    push_frame(8'h3C);
    bus_write(TXA, 32'h0000_003C);
    run_frame("f3C", 39, STA, 32'h2, 32'h0);
    read_chk("set wins", STA, 32'h2);
    @(negedge clk);

    // Store in the final STOP cycle is an overrun, not a new frame.
    push_frame(8'h96);
    bus_write(TXA, 32'h0000_0096);
    run_frame("f96", 39, TXA, 32'h0000_0011, 32'h0);
    chk1("f96 idle busy", busy_o, 1'b0);
    read_chk("f96 status", STA, 32'h6);
    read_chk("f96 txdata", TXA, 32'h96);
    @(negedge clk);
    chk1("f96 no frame tx", tx_o, 1'b1);
    chk1("f96 no frame busy", busy_o, 1'b0);
    bus_write(STA, 32'h4);
    read_chk("ovr clear only", STA, 32'h2);
    @(negedge clk);

    // Unaligned TXDATA address; unmapped address reads zero and ignores stores.
    push_frame(8'hC5);
    bus_write(32'h1001_0032, 32'h0000_00C5);
    run_frame("fC5", -1, STA, 32'h0, 32'h0);
    read_chk("unmapped read", 32'h1001_0038, 32'h0);
    @(negedge clk);
    bus_write(32'h1001_0038, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("unmapped tx %0d", i), tx_o, 1'b1);
      chk1($sformatf("unmapped busy %0d", i), busy_o, 1'b0);
      @(negedge clk);
    end
    read_chk("unmapped txdata", TXA, 32'hC5);
    @(negedge clk);
    bus_write(STA, 32'h2);
    @(negedge clk);

    // Back-to-back frames with exactly one idle cycle between them.
    push_frame(8'h01);
    push_frame(8'h80);
    bus_write(TXA, 32'h0000_0001);
    run_frame("f01", -1, STA, 32'h0, 32'h0);
    bus_write(TXA, 32'h0000_0080);
    run_frame("f80", -1, STA, 32'h0, 32'h0);
    read_chk("f80 txdata", TXA, 32'h80);
    @(negedge clk);

    // Asynchronous reset in the middle of a frame.
    bus_write(TXA, 32'h0000_00FF);
    repeat (12) @(negedge clk);
    chk1("pre reset busy", busy_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("async rst tx", tx_o, 1'b1);
    chk1("async rst busy", busy_o, 1'b0);
    read_chk("async rst status", STA, 32'h0);
    read_chk("async rst txdata", TXA, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_bits.delete();
    push_frame(8'h5A);
    bus_write(TXA, 32'h0000_005A);
    run_frame("f5A", -1, STA, 32'h0, 32'h0);
    read_chk("f5A status", STA, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
